// File: rtl/pulse_gate_counter.sv
// pulse_gate_counter: counts qualified single-cycle pulses over a programmable
// gate window and offers each completed total through a valid/ack handshake.
// Gating can be single-shot or continuous. Continuous mode re-arms with no
// dead cycle between windows.
module pulse_gate_counter #(
    parameter int CNT_W  = 16,
    parameter int GATE_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse_in,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              start,
    input  logic              continuous,
    input  logic              abort,
    output logic              busy,
    output logic [CNT_W-1:0]  count_out,
    output logic              count_ovf,
    output logic              count_valid,
    input  logic              count_ack,
    output logic              result_lost
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_nx;
    logic [GATE_W-1:0] len_q;
    logic [GATE_W-1:0] timer;
    logic              cont_q;
    logic [CNT_W-1:0]  acc;
    logic              acc_ovf;
    logic [CNT_W-1:0]  acc_inc;
    logic              ovf_inc;
    logic              last_cyc;
    logic              arm;
    logic              new_result;

    // Saturating increment: this cycle's pulse is folded in. The final-cycle
    // result is taken from here, so a pulse on the last gate cycle still counts.
    always_comb begin
        acc_inc = acc;
        ovf_inc = acc_ovf;
        if (pulse_in) begin
            if (acc == {CNT_W{1'b1}}) ovf_inc = 1'b1;
            else                      acc_inc = acc + CNT_W'(1);
        end
    end

    assign last_cyc = (state == RUN) && (timer == len_q - GATE_W'(1));
    assign busy     = (state == RUN);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state: abort outranks end-of-gate, so an abort on the last cycle yields no result.
    always_comb begin
        state_nx   = state;
        arm        = 1'b0;
        new_result = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                    arm      = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (last_cyc) begin
                    new_result = 1'b1;
                    state_nx   = cont_q ? RUN : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Gate timer and accumulator. Both clear at every window boundary, so the
    // next window starts on the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q   <= '0;
            cont_q  <= 1'b0;
            timer   <= '0;
            acc     <= '0;
            acc_ovf <= 1'b0;
        end else if (arm) begin
            len_q   <= (gate_len == '0) ? GATE_W'(1) : gate_len;
            cont_q  <= continuous;
            timer   <= '0;
            acc     <= '0;
            acc_ovf <= 1'b0;
        end else if (state == RUN) begin
            if (last_cyc || abort) begin
                timer   <= '0;
                acc     <= '0;
                acc_ovf <= 1'b0;
            end else begin
                timer   <= timer + GATE_W'(1);
                acc     <= acc_inc;
                acc_ovf <= ovf_inc;
            end
        end
    end

    // Result word and handshake. A new result wins over an ack in the same
    // cycle. Overwriting an unread, unacked result sets the sticky lost flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_out   <= '0;
            count_ovf   <= 1'b0;
            count_valid <= 1'b0;
            result_lost <= 1'b0;
        end else if (new_result) begin
            count_out   <= acc_inc;
            count_ovf   <= ovf_inc;
            count_valid <= 1'b1;
            if (count_valid && !count_ack) result_lost <= 1'b1;
        end else if (count_valid && count_ack) begin
            count_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pulse_gate_counter.sv
// Directed, table-driven bench for pulse_gate_counter.
// A narrow 4-bit counter makes saturation reachable in a short gate.
// Each row's inputs are applied for one clock, and the outputs are compared
// just after that edge.
module tb_pulse_gate_counter;

    localparam int CNT_W  = 4;
    localparam int GATE_W = 24;

    logic              clk = 1'b0;
    logic              rst;
    logic              pulse_in;
    logic [GATE_W-1:0] gate_len;
    logic              start;
    logic              continuous;
    logic              abort;
    logic              busy;
    logic [CNT_W-1:0]  count_out;
    logic              count_ovf;
    logic              count_valid;
    logic              count_ack;
    logic              result_lost;

    pulse_gate_counter #(.CNT_W(CNT_W), .GATE_W(GATE_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .pulse_in   (pulse_in),
        .gate_len   (gate_len),
        .start      (start),
        .continuous (continuous),
        .abort      (abort),
        .busy       (busy),
        .count_out  (count_out),
        .count_ovf  (count_ovf),
        .count_valid(count_valid),
        .count_ack  (count_ack),
        .result_lost(result_lost)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, start, cont, abort, pulse, ack;
        logic [23:0] glen;
        logic        busy, valid;
        logic [3:0]  cnt;
        logic        ovf, lost;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input logic r, s, c, a, p, k, input int gl,
                       input logic b, v, input int n, input logic o, l);
        vec_t t;
        t.rst = r; t.start = s; t.cont = c; t.abort = a; t.pulse = p; t.ack = k;
        t.glen = 24'(gl);
        t.busy = b; t.valid = v; t.cnt = 4'(n); t.ovf = o; t.lost = l;
        tbl.push_back(t);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int cyc;
        rst = 1'b1; start = 1'b0; continuous = 1'b0; abort = 1'b0;
        pulse_in = 1'b0; count_ack = 1'b0; gate_len = '0;

        // Columns:    rst st cn ab pu ak glen    busy vld cnt ovf lost
        add(1,0,0,0,0,0,0,   0,0,0,0,0);                         // reset
        // single shot, L=10, pulses on gate cycles 0,3,9; start/len change mid-run ignored
        add(0,1,0,0,0,0,10,  1,0,0,0,0);
        for (int k = 0; k < 10; k++)
            add(0, k==4, 0, 0, (k==0||k==3||k==9), 0, (k==4) ? 2 : 0,
                k<9, k==9, (k==9) ? 3 : 0, 0, 0);
        add(0,0,0,0,0,1,0,   0,0,3,0,0);                         // ack
        add(0,0,0,1,1,1,0,   0,0,3,0,0);                         // idle: pulse/abort/ack ignored
        // gate_len 0 -> one-cycle gate
        add(0,1,0,0,0,0,0,   1,0,3,0,0);
        add(0,0,0,0,1,0,0,   0,1,1,0,0);
        add(0,0,0,0,0,1,0,   0,0,1,0,0);
        // continuous, L=4, pulse every cycle, ack at each window start
        add(0,1,1,0,0,0,4,   1,0,1,0,0);
        for (int w = 0; w < 3; w++)
            for (int k = 0; k < 4; k++)
                add(0,0,0,0,1,(w>0 && k==0),0, 1,k==3,(w==0 && k<3) ? 1 : 4,0,0);
        add(0,0,0,1,0,1,0,   0,0,4,0,0);                         // abort + ack
        // saturation: L=20, pulse every cycle
        add(0,1,0,0,0,0,20,  1,0,4,0,0);
        for (int k = 0; k < 20; k++)
            add(0,0,0,0,1,0,0, k<19, k==19, (k==19) ? 15 : 4, k==19, 0);
        add(0,0,0,0,0,1,0,   0,0,15,1,0);
        add(0,1,0,0,0,0,3,   1,0,15,1,0);                        // next gate, 2 pulses
        add(0,0,0,0,1,0,0,   1,0,15,1,0);
        add(0,0,0,0,0,0,0,   1,0,15,1,0);
        add(0,0,0,0,1,0,0,   0,1,2,0,0);
        add(0,0,0,0,0,1,0,   0,0,2,0,0);
        // abort at gate cycle 5 of 10
        add(0,1,0,0,0,0,10,  1,0,2,0,0);
        for (int k = 0; k < 5; k++) add(0,0,0,0,1,0,0, 1,0,2,0,0);
        add(0,0,0,1,1,0,0,   0,0,2,0,0);
        add(0,0,0,0,1,0,0,   0,0,2,0,0);
        // abort on the final gate cycle beats the result
        add(0,1,0,0,0,0,2,   1,0,2,0,0);
        add(0,0,0,0,1,0,0,   1,0,2,0,0);
        add(0,0,0,1,1,0,0,   0,0,2,0,0);
        // overwrite: continuous L=3, ack only together with the second result
        add(0,1,1,0,0,0,3,   1,0,2,0,0);
        add(0,0,0,0,1,0,0,   1,0,2,0,0);
        add(0,0,0,0,0,0,0,   1,0,2,0,0);
        add(0,0,0,0,0,0,0,   1,1,1,0,0);
        add(0,0,0,0,1,0,0,   1,1,1,0,0);
        add(0,0,0,0,1,0,0,   1,1,1,0,0);
        add(0,0,0,0,0,1,0,   1,1,2,0,0);                         // ack + new: lost unchanged
        add(0,0,0,0,1,0,0,   1,1,2,0,0);
        add(0,0,0,0,1,0,0,   1,1,2,0,0);
        add(0,0,0,0,1,0,0,   1,1,3,0,1);                         // unacked overwrite
        add(0,0,0,1,0,1,0,   0,0,3,0,1);
        // reset mid-run, then a normal run
        add(0,1,0,0,0,0,5,   1,0,3,0,1);
        add(0,0,0,0,1,0,0,   1,0,3,0,1);
        add(1,0,0,0,1,0,0,   0,0,0,0,0);
        add(0,1,0,0,0,0,2,   1,0,0,0,0);
        add(0,0,0,0,1,0,0,   1,0,0,0,0);
        add(0,0,0,0,1,0,0,   0,1,2,0,0);
        add(0,0,0,0,0,1,0,   0,0,2,0,0);

        foreach (tbl[i]) begin
            rst = tbl[i].rst; start = tbl[i].start; continuous = tbl[i].cont;
            abort = tbl[i].abort; pulse_in = tbl[i].pulse; count_ack = tbl[i].ack;
            gate_len = tbl[i].glen;
            step();
            checks++;
            if ({busy, count_valid, count_out, count_ovf, result_lost} !==
                {tbl[i].busy, tbl[i].valid, tbl[i].cnt, tbl[i].ovf, tbl[i].lost}) begin
                errors++;
                $display("FAIL vec%0d: got busy=%b vld=%b cnt=%0d ovf=%b lost=%b expected busy=%b vld=%b cnt=%0d ovf=%b lost=%b",
                         i, busy, count_valid, count_out, count_ovf, result_lost,
                         tbl[i].busy, tbl[i].valid, tbl[i].cnt, tbl[i].ovf, tbl[i].lost);
            end
        end

        // Hand sequence: L=6, pulses on gate cycles 0 and 5; wait (bounded) for the result.
        rst = 1'b0; abort = 1'b0; count_ack = 1'b0; continuous = 1'b0;
        start = 1'b1; gate_len = 24'd6; pulse_in = 1'b0;
        step();
        start = 1'b0;
        cyc = 0;
        while (!count_valid && cyc < 30) begin
            pulse_in = (cyc == 0 || cyc == 5);
            step();
            cyc++;
        end
        pulse_in = 1'b0;
        check("latency_valid", int'(count_valid), 1);
        check("latency_cycles", cyc, 6);
        check("latency_count", int'(count_out), 2);
        check("latency_idle", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pulse_gate_counter.md
Name: pulse_gate_counter

Overview:
Downstream consumer of the pulse discriminator. Counts qualified single-cycle pulses (discriminator output) over a programmable gate window of N clock cycles and latches the total as a result word. The result is offered to a register/readout stage via a valid/ack handshake. Supports single-shot and back-to-back (continuous, zero dead time) gating.

Parameters:
CNT_W, 16, width of pulse accumulator and result word
GATE_W, 24, width of gate length / gate timer

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
pulse_in  input  1  qualified pulse, one cycle wide, from discriminator
gate_len  input  GATE_W  gate length in clk cycles; latched on start; 0 treated as 1
start  input  1  begin gating (accepted in IDLE only)
continuous  input  1  latched on start; 1 = re-arm automatically after each gate
abort  input  1  stop gating, discard partial count
busy  output  1  high in RUN
count_out  output  CNT_W  last completed gate count
count_ovf  output  1  saturation flag accompanying count_out
count_valid  output  1  count_out holds unread result
count_ack  input  1  consumer has taken result
result_lost  output  1  sticky: unread result overwritten

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; busy=0, count_out=0, count_ovf=0, count_valid=0, result_lost=0; accumulator, gate timer, latched gate_len/continuous cleared. Reset mid-gate discards everything; no result produced.
- States: IDLE, RUN.
- IDLE: start=1 -> RUN next cycle; latch gate_len (0->1) and continuous; accumulator=0, timer=0. abort ignored.
- RUN: each cycle is a gate cycle; pulse_in=1 increments accumulator. Timer counts 0..L-1; RUN lasts exactly L cycles for latched length L.
- Final gate cycle (timer==L-1): pulse_in that cycle is counted. Next edge: count_out <= final accumulator, count_ovf <= saturation flag, count_valid <= 1. Result latency: count_valid rises 1 cycle after final gate cycle.
- After final gate cycle: continuous=1 -> stay RUN, timer=0, accumulator=0 (or 1 if... no: accumulator cleared, next cycle is first gate cycle of next window; zero dead time); continuous=0 -> IDLE, busy=0.
- start in RUN ignored. gate_len changes in RUN ignored until next start.
- abort=1 in RUN -> IDLE next cycle, accumulator discarded, no result, count_out/count_valid unchanged. abort on final gate cycle takes priority: no result.
- Accumulator arithmetic: unsigned, saturates at 2^CNT_W-1; a pulse arriving while saturated sets overflow flag; flag cleared with accumulator at gate start.
- Handshake: count_valid stays 1 until count_ack=1 while count_valid=1; then count_valid=0 next cycle. count_ack with count_valid=0 ignored.
- New result while count_valid=1 and no ack that cycle: count_out overwritten, count_valid stays 1, result_lost <= 1 (sticky until rst).
- New result and count_ack in same cycle: new result loaded, count_valid stays 1, result_lost unchanged.
- pulse_in in IDLE ignored.

Test Plan:
- Single-shot: gate_len=10, start, pulses on gate cycles 0,3,9 -> busy high 10 cycles, count_valid rises 1 cycle after gate cycle 9, count_out=3, count_ovf=0; state IDLE.
- Continuous: gate_len=4, continuous=1, pulse every cycle, ack each result -> count_out=4 every 4 cycles, no gap cycle, result_lost=0.
- Saturation: CNT_W=4, gate_len=20, pulse every cycle -> count_out=15, count_ovf=1; next gate with 2 pulses -> count_out=2, count_ovf=0.
- Overwrite: continuous, gate_len=3, never ack -> second result sets result_lost=1, count_out=newest; simultaneous ack+new result -> result_lost unchanged.
- Abort/reset: abort at gate cycle 5 of 10 -> IDLE, no count_valid; rst mid-RUN -> all outputs 0, subsequent start runs normally.
- gate_len=0 -> 1-cycle gate; pulse on that cycle gives count_out=1.
